imem_loader: RTL

//   Boot-time writer for the instruction memory, filling the role opposite the CPU fetch path.

---
 rtl/imem_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a length-prefixed byte stream into
// 32-bit words, writes them to imem and releases the CPU once the checksum matches.
//
// state   | meaning
// --------+-------------------------------------------------
// S_HDR0  | waiting for LEN_LO
// S_HDR1  | waiting for LEN_HI, range-checks the word count
// S_DATA  | assembling payload words, one imem write per 4 bytes
// S_CSUM  | waiting for the checksum byte
// S_DONE  | image accepted, CPU released
// S_ERROR | length or checksum failure, CPU held in reset
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_loaded,
    output logic              cpu_run,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t      state;
    state_t      state_next;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
    logic [7:0]  csum_acc;
    logic        accept;
    logic [15:0] len_full;
    logic        last_word;

    // Gated by reset so the stream cannot be accepted while reset is held.
    assign rx_ready  = reset & (state != S_DONE) & (state != S_ERROR);
    assign accept    = rx_valid & rx_ready;
    assign len_full  = {rx_data, len[7:0]};
    assign last_word = (16'(words_loaded) + 16'd1) == len;

    always_comb begin
        state_next = state;
        case (state)
            S_HDR0: if (accept) state_next = S_HDR1;
            S_HDR1: begin
                if (accept) begin
                    if ({1'b0, len_full} > MAX_WORDS) state_next = S_ERROR;
                    else if (len_full == 16'd0)       state_next = S_CSUM;
                    else                              state_next = S_DATA;
                end
            end
            S_DATA: if (accept && byte_idx == 2'd3 && last_word) state_next = S_CSUM;
            S_CSUM: begin
                if (accept) state_next = (rx_data == csum_acc) ? S_DONE : S_ERROR;
            end
            S_DONE:  state_next = S_DONE;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_HDR0;
        endcase
        if (restart) state_next = S_HDR0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_HDR0;
            len          <= '0;
            byte_idx     <= '0;
            asm_q        <= '0;
            csum_acc     <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            cpu_run      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state   <= state_next;
            imem_we <= 1'b0;
            if (restart) begin
                len          <= '0;
                byte_idx     <= '0;
                csum_acc     <= '0;
                words_loaded <= '0;
                cpu_run      <= 1'b0;
                done         <= 1'b0;
                error        <= 1'b0;
            end else begin
                done    <= (state == S_DONE);
                cpu_run <= (state == S_DONE);
                error   <= (state_next == S_ERROR);
                if (accept) begin
                    case (state)
                        S_HDR0: begin
                            len[7:0]     <= rx_data;
                            byte_idx     <= '0;
                            csum_acc     <= '0;
                            words_loaded <= '0;
                        end
                        S_HDR1: len[15:8] <= rx_data;
                        S_DATA: begin
                            csum_acc <= csum_acc ^ rx_data;
                            byte_idx <= byte_idx + 2'd1;
                            // Little-endian: earlier bytes shift down toward [7:0].
                            if (byte_idx == 2'd3) begin
                                imem_we      <= 1'b1;
                                imem_waddr   <= words_loaded[ADDR_W-1:0];
                                imem_wdata   <= {rx_data, asm_q};
                                words_loaded <= words_loaded + 1'b1;
                            end else begin
                                asm_q <= {rx_data, asm_q[23:8]};
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
